// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame decoder: FSM states, error codes and
// the default start-of-frame byte.
package uart_frame_pkg;

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;

    typedef enum logic [2:0] {
        ST_HUNT    = S_HUNT,
        ST_LEN     = S_LEN,
        ST_CMD     = S_CMD,
        ST_PAYLOAD = S_PAYLOAD,
        ST_CHK     = S_CHK
    } state_t;

    localparam logic [1:0] E_NONE = 2'd0;
    localparam logic [1:0] E_LEN  = 2'd1;
    localparam logic [1:0] E_CHK  = 2'd2;
    localparam logic [1:0] E_TMO  = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one combinational read port, cleared on reset.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses beyond DEPTH (non power-of-two depths) read as zero.
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder behind the UART receiver: hunts for SYNC, assembles a
// length-prefixed checksummed frame and holds it for the controller.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 21700
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       arrived,
    input  logic [7:0]                 data,
    output logic                       frame_valid,
    output logic [7:0]                 frame_cmd,
    output logic [7:0]                 frame_len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    input  logic                       frame_ack,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       overrun,
    output logic [2:0]                 dbg_state
);

    localparam int         AW       = $clog2(MAX_LEN);
    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    // Handshake: frame_valid rises with a good frame and holds until frame_ack
    // is sampled high; frame_valid falls the next cycle. Ack while idle is ignored.

    state_t        state_q, state_n;
    logic          byte_stb;
    logic [7:0]    len_q, len_n, cmd_q, cmd_n, acc_q, acc_n, idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          fv_q, fv_n, err_q, err_n, ovr_q, ovr_n;
    logic [7:0]    fcmd_q, fcmd_n, flen_q, flen_n;
    logic [1:0]    code_q, code_n;
    logic          buf_we, hold;

    assign hold = fv_q && !frame_ack;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            byte_stb <= 1'b0;
            state_q  <= ST_HUNT;
            len_q    <= '0;
            cmd_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            fcmd_q   <= '0;
            flen_q   <= '0;
            err_q    <= 1'b0;
            code_q   <= E_NONE;
            ovr_q    <= 1'b0;
        end else begin
            byte_stb <= arrived;
            state_q  <= state_n;
            len_q    <= len_n;
            cmd_q    <= cmd_n;
            acc_q    <= acc_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            fv_q     <= fv_n;
            fcmd_q   <= fcmd_n;
            flen_q   <= flen_n;
            err_q    <= err_n;
            code_q   <= code_n;
            ovr_q    <= ovr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        cmd_n   = cmd_q;
        acc_n   = acc_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        fv_n    = fv_q;
        fcmd_n  = fcmd_q;
        flen_n  = flen_q;
        err_n   = 1'b0;
        code_n  = code_q;
        ovr_n   = ovr_q;
        buf_we  = 1'b0;

        if (fv_q && frame_ack) begin
            fv_n  = 1'b0;
            ovr_n = 1'b0;
        end

        if (byte_stb) begin
            cnt_n = CW'(TIMEOUT);
            if (hold) begin
                ovr_n = 1'b1;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        if (data == SYNC) state_n = ST_LEN;
                    end
                    ST_LEN: begin
                        if (data > MAX_LEN8) begin
                            err_n   = 1'b1;
                            code_n  = E_LEN;
                            state_n = ST_HUNT;
                        end else begin
                            len_n   = data;
                            acc_n   = data;
                            state_n = ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd_n   = data;
                        acc_n   = acc_q + data;
                        idx_n   = 8'd0;
                        state_n = (len_q == 8'd0) ? ST_CHK : ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        buf_we = 1'b1;
                        acc_n  = acc_q + data;
                        idx_n  = idx_q + 8'd1;
                        if (idx_q + 8'd1 == len_q) state_n = ST_CHK;
                    end
                    ST_CHK: begin
                        if (data == acc_q) begin
                            fv_n   = 1'b1;
                            fcmd_n = cmd_q;
                            flen_n = len_q;
                        end else begin
                            err_n  = 1'b1;
                            code_n = E_CHK;
                        end
                        state_n = ST_HUNT;
                    end
                    default: state_n = ST_HUNT;
                endcase
            end
        end else if (state_q != ST_HUNT) begin
            // Fires on the cycle the counter would reach zero.
            if (cnt_q <= CW'(1)) begin
                err_n   = 1'b1;
                code_n  = E_TMO;
                state_n = ST_HUNT;
            end else begin
                cnt_n = cnt_q - CW'(1);
            end
        end
    end

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .Clock (Clock),
        .Reset (Reset),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign frame_valid = fv_q;
    assign frame_cmd   = fcmd_q;
    assign frame_len   = flen_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign overrun     = ovr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: hand-computed frames, errors, timeout,
// overrun, simultaneous ack and reset behaviour.
module tb_uart_frame_rx;

    localparam int TIMEOUT = 21700;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       arrived;
    logic [7:0] data;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       err;
    logic [1:0] err_code;
    logic       overrun;
    logic [2:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int err_cnt     = 0;

    uart_frame_rx #(.SYNC(8'hA5), .MAX_LEN(16), .TIMEOUT(TIMEOUT)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .arrived     (arrived),
        .data        (data),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .err         (err),
        .err_code    (err_code),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) if (err) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one cycle; data is held so it is stable when byte_stb is high.
    task automatic send_byte(input logic [7:0] b);
        @(negedge Clock);
        arrived = 1'b1;
        data    = b;
        @(negedge Clock);
        arrived = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] b[8], input int n);
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, {24'b0, rd_data}, {24'b0, exp});
    endtask

    task automatic ack_chk(input string tag);
        @(negedge Clock);
        frame_ack = 1'b1;
        @(negedge Clock);
        frame_ack = 1'b0;
        check(tag, {31'b0, frame_valid}, 32'd0);
    endtask

    int e0;
    int waited;

    initial begin
        Reset = 1'b0; arrived = 1'b0; data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
        repeat (3) @(negedge Clock);
        check("rst_valid", {31'b0, frame_valid}, 32'd0);
        check("rst_cmd", {24'b0, frame_cmd}, 32'd0);
        check("rst_len", {24'b0, frame_len}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        check("rst_ovr", {31'b0, overrun}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);
        read_chk("rst_buf", 4'd0, 8'h00);
        Reset = 1'b1;

        // Good frame: 02+10+33+44 = 89
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h33, 8'h44, 8'h89, 8'h00, 8'h00}, 6);
        check("good_not_yet", {31'b0, frame_valid}, 32'd0);
        @(negedge Clock);
        check("good_valid", {31'b0, frame_valid}, 32'd1);
        check("good_cmd", {24'b0, frame_cmd}, 32'h10);
        check("good_len", {24'b0, frame_len}, 32'd2);
        read_chk("good_rd0", 4'd0, 8'h33);
        read_chk("good_rd1", 4'd1, 8'h44);
        ack_chk("good_release");

        // Bad checksum: 01+20+55 = 76, 00 sent
        e0 = err_cnt;
        send_seq('{8'hA5, 8'h01, 8'h20, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        repeat (2) @(negedge Clock);
        check("badchk_pulses", err_cnt - e0, 32'd1);
        check("badchk_code", {30'b0, err_code}, 32'd2);
        check("badchk_valid", {31'b0, frame_valid}, 32'd0);

        // Zero-length frame: 00+07 = 07
        send_seq('{8'hA5, 8'h00, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        @(negedge Clock);
        check("zero_valid", {31'b0, frame_valid}, 32'd1);
        check("zero_len", {24'b0, frame_len}, 32'd0);
        check("zero_cmd", {24'b0, frame_cmd}, 32'h07);
        ack_chk("zero_release");

        // Garbage then oversize length 0x11
        e0 = err_cnt;
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        repeat (2) @(negedge Clock);
        check("badlen_pulses", err_cnt - e0, 32'd1);
        check("badlen_code", {30'b0, err_code}, 32'd1);
        check("badlen_state", {29'b0, dbg_state}, 32'd0);

        // Embedded sync as payload: 01+01+A5 = A7
        send_seq('{8'hA5, 8'h01, 8'h01, 8'hA5, 8'hA7, 8'h00, 8'h00, 8'h00}, 5);
        @(negedge Clock);
        check("embed_valid", {31'b0, frame_valid}, 32'd1);
        check("embed_cmd", {24'b0, frame_cmd}, 32'h01);
        read_chk("embed_rd0", 4'd0, 8'hA5);
        ack_chk("embed_release");

        // Overrun: 01+01+11 = 13, then A5 01 while held
        send_seq('{8'hA5, 8'h01, 8'h01, 8'h11, 8'h13, 8'h00, 8'h00, 8'h00}, 5);
        @(negedge Clock);
        check("ovr_valid", {31'b0, frame_valid}, 32'd1);
        check("ovr_before", {31'b0, overrun}, 32'd0);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        @(negedge Clock);
        check("ovr_set", {31'b0, overrun}, 32'd1);
        check("ovr_still_valid", {31'b0, frame_valid}, 32'd1);
        check("ovr_state", {29'b0, dbg_state}, 32'd0);
        read_chk("ovr_buf_frozen", 4'd0, 8'h11);
        check("ovr_len_frozen", {24'b0, frame_len}, 32'd1);
        ack_chk("ovr_release");
        check("ovr_cleared", {31'b0, overrun}, 32'd0);

        // Simultaneous ack and sync byte: 01+02+22 = 25 held first
        send_seq('{8'hA5, 8'h01, 8'h02, 8'h22, 8'h25, 8'h00, 8'h00, 8'h00}, 5);
        @(negedge Clock);
        check("sim_held", {31'b0, frame_valid}, 32'd1);
        arrived = 1'b1;
        data    = 8'hA5;
        @(negedge Clock);
        arrived   = 1'b0;
        frame_ack = 1'b1;
        @(negedge Clock);
        frame_ack = 1'b0;
        check("sim_ovr", {31'b0, overrun}, 32'd0);
        check("sim_released", {31'b0, frame_valid}, 32'd0);
        check("sim_state_len", {29'b0, dbg_state}, 32'd1);
        // 01+03+44 = 48
        send_seq('{8'h01, 8'h03, 8'h44, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        @(negedge Clock);
        check("sim_next_valid", {31'b0, frame_valid}, 32'd1);
        check("sim_next_cmd", {24'b0, frame_cmd}, 32'h03);
        read_chk("sim_next_rd0", 4'd0, 8'h44);
        check("sim_next_ovr", {31'b0, overrun}, 32'd0);
        ack_chk("sim_next_release");

        // Timeout: last byte sampled at edge T, err must be high right after edge T+TIMEOUT
        e0 = err_cnt;
        send_seq('{8'hA5, 8'h03, 8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        waited = 0;
        while (waited < TIMEOUT + 20) begin
            @(negedge Clock);
            waited++;
            if (err) break;
        end
        check("tmo_seen", {31'b0, err}, 32'd1);
        check("tmo_delay", waited - 1, TIMEOUT);
        check("tmo_code", {30'b0, err_code}, 32'd3);
        @(negedge Clock);
        check("tmo_one_cycle", {31'b0, err}, 32'd0);
        check("tmo_pulses", err_cnt - e0, 32'd1);
        check("tmo_state", {29'b0, dbg_state}, 32'd0);

        // Reset mid-frame
        e0 = err_cnt;
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        @(negedge Clock);
        check("mid_state", {29'b0, dbg_state}, 32'd3);
        Reset = 1'b0;
        #1;
        check("mid_state_rst", {29'b0, dbg_state}, 32'd0);
        check("mid_code_rst", {30'b0, err_code}, 32'd0);
        check("mid_valid_rst", {31'b0, frame_valid}, 32'd0);
        check("mid_cmd_rst", {24'b0, frame_cmd}, 32'd0);
        read_chk("mid_buf_rst", 4'd0, 8'h00);
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        repeat (5) @(negedge Clock);
        check("mid_no_err", err_cnt - e0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
